ec_probe_driver: RTL and testbench
==================================

Name: ec_probe_driver

Overview:
- Downstream consumer of the 2-bit GPIO output register on the peripheral bus; turns the software-written mode code into an AC excitation sequence for the electrical-conductivity probe.
- Drives an H-bridge with alternating polarity and a dead time between phases, so the probe never sees a net DC bias.
- Emits a one-cycle ADC sample strobe at a fixed offset inside each drive phase, plus busy/done status that software can read back.

Parameters:
- HALF_PERIOD, 500, clock cycles each polarity is driven (>=2)
- DEAD_TIME, 10, clock cycles with both bridge legs off between phases (>=1)
- SAMPLE_OFFSET, 400, cycle index within a drive phase at which adc_sample fires (0..HALF_PERIOD-1)
- BURST_CYCLES, 4, full excitation periods per single-shot measurement (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mode  in  2  mode code from GPIO output: 00 idle, 01 single burst, 10 continuous, 11 reserved (treated as 00)
- probe_a  out  1  H-bridge leg A; high in the positive phase
- probe_b  out  1  H-bridge leg B; high in the negative phase
- adc_sample  out  1  one-cycle strobe requesting an ADC conversion
- adc_pol  out  1  polarity of the current/last strobe: 0 positive, 1 negative
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse at the end of a single burst
- sample_count  out  16  strobe counter (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all outputs are 0, the FSM is in IDLE, and all counters and mode_q are cleared. This also applies mid-sequence: both bridge legs drop on the same edge reset asserts.
- All outputs are registered. probe_a and probe_b are never both 1.
- mode_q holds mode from the previous cycle.
- Single-shot start condition: mode==01 and mode_q!=01. This condition is edge-triggered; holding 01 does not retrigger.
- FSM states: IDLE, DRIVE_POS, DEAD_1, DRIVE_NEG, DEAD_2.
- IDLE:
  - Moves to DRIVE_POS if mode==10, or if the single-shot start condition holds.
  - probe_a is high in the first cycle after the edge that sampled the start.
- DRIVE_POS: probe_a=1. phase_cnt runs 0..HALF_PERIOD-1, then goes to DEAD_1.
- DEAD_1: both legs 0 for DEAD_TIME cycles, then goes to DRIVE_NEG.
- DRIVE_NEG: probe_b=1 for HALF_PERIOD cycles, then goes to DEAD_2.
- DEAD_2: both legs 0 for DEAD_TIME cycles. At the end, the FSM decides:
  - Continuous run, mode still 10: go to DRIVE_POS.
  - Single burst, period_cnt+1 < BURST_CYCLES: increment period_cnt and go to DRIVE_POS.
  - Otherwise: go to IDLE.
- One full period is 2*(HALF_PERIOD+DEAD_TIME) cycles.
- adc_sample fires one cycle when phase_cnt==SAMPLE_OFFSET:
  - in DRIVE_POS with adc_pol=0;
  - in DRIVE_NEG with adc_pol=1.
  - adc_pol holds its value between strobes.
- done pulses for one cycle in the first IDLE cycle after a single burst completes. done is never asserted when a continuous run ends.
- Charge balance: the FSM only returns to IDLE from DEAD_2.
  - A mode change (to 00, 11, or between 01 and 10) mid-period never truncates a period.
  - Leaving 10 finishes the current period and then goes IDLE.
  - Changing to 10 during a burst converts the burst to continuous.
  - Changing away from 01 during a burst still completes all BURST_CYCLES periods.
- The run type (single or continuous) is latched in DRIVE_POS entry and re-evaluated only at the end of DEAD_2.
- Counter widths are $clog2 of the parameter maximum. Counters never wrap within a phase.

Optional Feature:
- Macro: EC_SAMPLE_COUNT_EN.
- Defined: sample_count increments on every adc_sample strobe, wraps from 0xFFFF to 0, and clears on reset and on every IDLE->DRIVE_POS transition.
- Undefined: sample_count is tied to 0 and no counter logic is synthesised. The port stays present.

Test Plan:
- Parameters for all scenarios: HALF_PERIOD=8, DEAD_TIME=2, SAMPLE_OFFSET=6, BURST_CYCLES=2.
- Reset, then mode=00 for 10 cycles -> all outputs 0, busy=0.
- mode 00->01 and held -> busy for exactly 40 cycles.
  - probe_a 8 / off 2 / probe_b 8 / off 2, repeated twice.
  - 4 adc_sample pulses with adc_pol 0,1,0,1.
  - done 1-cycle pulse; no retrigger while mode stays 01.
  - sample_count=4 with EC_SAMPLE_COUNT_EN, 0 without.
- mode=10 for 50 cycles, then 00 -> excitation continues to the end of period 3 (60 cycles after start), then IDLE with done=0.
- mode 01 then 00 after 5 cycles -> full 40-cycle burst still completes and done pulses.
- rst asserted 3 cycles into DRIVE_NEG -> probe_b and busy go 0 asynchronously; after release the FSM stays IDLE until a new 01 edge.
- Every cycle of all runs: probe_a&probe_b==0, and at least 2 off cycles occur between any polarity change.

Source files
------------

// File: rtl/ec_probe_driver.sv
// ec_probe_driver: AC excitation sequencer for the EC probe H-bridge.
// It alternates the bridge polarity, inserts dead time between the drive
// phases, and strobes the ADC at a fixed offset inside each drive phase.
// Optional feature macro: EC_SAMPLE_COUNT_EN enables the 16-bit strobe counter.
// When the macro is undefined, sample_count is tied to 0.
module ec_probe_driver #(
  parameter int HALF_PERIOD   = 500,
  parameter int DEAD_TIME     = 10,
  parameter int SAMPLE_OFFSET = 400,
  parameter int BURST_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  output logic        probe_a,
  output logic        probe_b,
  output logic        adc_sample,
  output logic        adc_pol,
  output logic        busy,
  output logic        done,
  output logic [15:0] sample_count
);

  localparam int CNT_MAX = (HALF_PERIOD > DEAD_TIME) ? HALF_PERIOD : DEAD_TIME;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;

  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] DT_LAST = CW'(DEAD_TIME - 1);
  localparam logic [CW-1:0] SMP_AT  = CW'(SAMPLE_OFFSET);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRIVE_POS = 3'd1,
    DEAD_1    = 3'd2,
    DRIVE_NEG = 3'd3,
    DEAD_2    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   period_q, period_d;
  logic            cont_q, cont_d;
  logic [1:0]      mode_q;
  logic            done_d, smp_d, pol_d;
  logic [31:0]     per_nxt;

  logic probe_a_q, probe_b_q, adc_sample_q, adc_pol_q, busy_q, done_q;

  assign per_nxt = 32'(period_q) + 32'd1;

  // Next-state logic: phase sequencing and end-of-period run decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    period_d = period_q;
    cont_d   = cont_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mode == 2'b10 || (mode == 2'b01 && mode_q != 2'b01)) begin
          state_d  = DRIVE_POS;
          period_d = '0;
          cont_d   = (mode == 2'b10);
        end
      end
      DRIVE_POS: if (cnt_q == HP_LAST) begin state_d = DEAD_1;    cnt_d = '0; end
      DEAD_1:    if (cnt_q == DT_LAST) begin state_d = DRIVE_NEG; cnt_d = '0; end
      DRIVE_NEG: if (cnt_q == HP_LAST) begin state_d = DEAD_2;    cnt_d = '0; end
      DEAD_2: begin
        if (cnt_q == DT_LAST) begin
          cnt_d = '0;
          // Only exit point to IDLE, so every started period is completed.
          if (mode == 2'b10) begin
            state_d  = DRIVE_POS;
            cont_d   = 1'b1;
            period_d = '0;
          end else if (!cont_q && per_nxt < BURST_CYCLES) begin
            state_d  = DRIVE_POS;
            period_d = period_q + 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = !cont_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe decode on next state, so the registered strobe lines up with its phase cycle.
  always_comb begin
    smp_d = 1'b0;
    pol_d = adc_pol_q;
    if ((state_d == DRIVE_POS || state_d == DRIVE_NEG) && cnt_d == SMP_AT) begin
      smp_d = 1'b1;
      pol_d = (state_d == DRIVE_NEG);
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      cont_q   <= 1'b0;
      mode_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      cont_q   <= cont_d;
      mode_q   <= mode;
    end
  end

  // Registered outputs; legs derive from a single state so they are mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_a_q    <= 1'b0;
      probe_b_q    <= 1'b0;
      adc_sample_q <= 1'b0;
      adc_pol_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      probe_a_q    <= (state_d == DRIVE_POS);
      probe_b_q    <= (state_d == DRIVE_NEG);
      adc_sample_q <= smp_d;
      adc_pol_q    <= pol_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= done_d;
    end
  end

  assign probe_a    = probe_a_q;
  assign probe_b    = probe_b_q;
  assign adc_sample = adc_sample_q;
  assign adc_pol    = adc_pol_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef EC_SAMPLE_COUNT_EN
  logic        run_start;
  logic [15:0] scnt_q;

  assign run_start = (state_q == IDLE) && (state_d == DRIVE_POS);

  // Strobe counter: restarts with each new run, wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               scnt_q <= '0;
    else if (run_start)    scnt_q <= '0;
    else if (adc_sample_q) scnt_q <= scnt_q + 16'd1;
  end

  assign sample_count = scnt_q;
`else
  assign sample_count = 16'd0;
`endif

endmodule

// File: tb/tb_ec_probe_driver.sv
// tb_ec_probe_driver: randomized and directed checks of ec_probe_driver
// against a period-position reference model.
module tb_ec_probe_driver;

  localparam int HP  = 8;
  localparam int DT  = 2;
  localparam int SO  = 6;
  localparam int BC  = 2;
  localparam int PER = 2 * (HP + DT);

`ifdef EC_SAMPLE_COUNT_EN
  localparam int SC_BURST = 2 * BC;
`else
  localparam int SC_BURST = 0;
`endif

  logic        clk, rst;
  logic [1:0]  mode;
  logic        probe_a, probe_b, adc_sample, adc_pol, busy, done;
  logic [15:0] sample_count;

  int total = 0;
  int bad   = 0;

  ec_probe_driver #(
    .HALF_PERIOD(HP), .DEAD_TIME(DT), .SAMPLE_OFFSET(SO), .BURST_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .probe_a(probe_a), .probe_b(probe_b), .adc_sample(adc_sample),
    .adc_pol(adc_pol), .busy(busy), .done(done), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: position within the current excitation period
  logic       m_act, m_cont, e_a, e_b, e_smp, e_pol, e_done;
  int         m_pos, m_nper, m_sc;
  logic [1:0] m_mprev;
  int         last_pol, offc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_cont = 0; m_pos = 0; m_nper = 0; m_sc = 0; m_mprev = 2'b00;
    e_a = 0; e_b = 0; e_smp = 0; e_pol = 0; e_done = 0;
  endtask

  task automatic model_step();
    logic start;
    start  = (mode == 2'b01) && (m_mprev != 2'b01);
    e_done = 0;
    if (!m_act) begin
      if (mode == 2'b10 || start) begin
        m_act = 1; m_pos = 0; m_nper = 0; m_cont = (mode == 2'b10); m_sc = 0;
      end
    end else if (m_pos == PER - 1) begin
      if (mode == 2'b10) begin
        m_pos = 0; m_cont = 1;
      end else if (!m_cont && m_nper + 1 < BC) begin
        m_nper++; m_pos = 0;
      end else begin
        m_act = 0; e_done = !m_cont;
      end
    end else begin
      m_pos++;
    end
    m_mprev = mode;
    e_a   = m_act && (m_pos < HP);
    e_b   = m_act && (m_pos >= HP + DT) && (m_pos < 2 * HP + DT);
    e_smp = m_act && (m_pos == SO || m_pos == HP + DT + SO);
    if (e_smp) begin
      e_pol = (m_pos >= HP);
      m_sc  = (m_sc + 1) & 16'hFFFF;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    chk("outs", {26'd0, probe_a, probe_b, adc_sample, adc_pol, busy, done},
                {26'd0, e_a, e_b, e_smp, e_pol, m_act, e_done});
    chk("excl", {31'd0, probe_a & probe_b}, 32'd0);
    if (!m_act) begin
`ifdef EC_SAMPLE_COUNT_EN
      chk("scnt", {16'd0, sample_count}, m_sc);
`else
      chk("scnt", {16'd0, sample_count}, 32'd0);
`endif
    end
    if (probe_a) begin
      if (last_pol == 2) chk("gap_ba", {31'd0, offc >= DT}, 32'd1);
      last_pol = 1; offc = 0;
    end else if (probe_b) begin
      if (last_pol == 1) chk("gap_ab", {31'd0, offc >= DT}, 32'd1);
      last_pol = 2; offc = 0;
    end else begin
      offc++;
    end
  endtask

  // start a run with mode m0, optionally switch to m1 after chg ticks, measure until idle
  task automatic run_measure(input logic [1:0] m0, input int chg, input logic [1:0] m1,
                             output int nbusy, output int nsmp, output int ndone,
                             output logic [3:0] pols);
    nbusy = 0; nsmp = 0; ndone = 0; pols = 4'h0;
    mode = m0;
    for (int k = 0; k < 400; k++) begin
      if (k == chg) mode = m1;
      tick();
      if (busy) nbusy++;
      if (adc_sample) begin
        if (nsmp < 4) pols[nsmp] = adc_pol;
        nsmp++;
      end
      if (done) ndone++;
      if (!busy && nbusy > 0) break;
    end
    if (busy) chk("run_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int nb, ns, nd, idle_busy;
    logic [3:0] pl;

    last_pol = 0; offc = 0;
    rst = 1'b1; mode = 2'b00;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // idle with mode 00
    repeat (10) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // single burst, mode held at 01
    run_measure(2'b01, -1, 2'b01, nb, ns, nd, pl);
    chk("burst_len", nb, 2 * BC * (HP + DT));
    chk("burst_smp", ns, 2 * BC);
    chk("burst_pol", {28'd0, pl}, 32'h0000000A);
    chk("burst_done", nd, 1);
    chk("burst_scnt", {16'd0, sample_count}, SC_BURST);
    idle_busy = 0;
    repeat (10) begin tick(); if (busy) idle_busy++; end
    chk("no_retrigger", idle_busy, 0);

    // continuous for 50 cycles, then 00: finish period 3
    mode = 2'b00;
    repeat (3) tick();
    run_measure(2'b10, 50, 2'b00, nb, ns, nd, pl);
    chk("cont_len", nb, 3 * PER);
    chk("cont_done", nd, 0);

    // burst with 01 dropped after 5 cycles
    repeat (3) tick();
    run_measure(2'b01, 5, 2'b00, nb, ns, nd, pl);
    chk("short01_len", nb, 2 * BC * (HP + DT));
    chk("short01_done", nd, 1);

    // async reset 3 cycles into DRIVE_NEG
    repeat (3) tick();
    mode = 2'b01;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (m_act && m_pos == HP + DT + 3) break;
    end
    chk("pre_rst_b", {31'd0, probe_b}, 32'd1);
    #2;
    rst = 1'b1; mode = 2'b00;
    #1;
    chk("rst_probe_b", {31'd0, probe_b}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    idle_busy = 0;
    repeat (5) begin tick(); if (busy) idle_busy++; end
    chk("post_rst_idle", idle_busy, 0);
    mode = 2'b01;
    tick();
    chk("restart", {31'd0, busy & probe_a}, 32'd1);
    mode = 2'b00;
    repeat (60) tick();

    // randomized mode changes
    for (int s = 0; s < 40; s++) begin
      mode = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) tick();
    end
    mode = 2'b00;
    repeat (100) tick();
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
